// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner encoding,
// and a helper that turns a one-hot grant into an owner.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_IFU = 1'b0,
    ARB_LSU = 1'b1
  } arb_owner_e;

  localparam int WMASK_W = 8;

  // Grant vector bit 0 is the IFU, bit 1 the LSU.
  function automatic arb_owner_e owner_from_grant(input logic [1:0] grant);
    return grant[1] ? ARB_LSU : ARB_IFU;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the side
// that did not win last time.
import mem_arbiter_pkg::*;

module arb_rr2 (
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  arb_owner_e last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = ifu_valid && (!lsu_valid || (last_grant == ARB_LSU));
    grant[1] = lsu_valid && (!ifu_valid || (last_grant == ARB_IFU));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: round-robin grant, a single
// outstanding transaction, response routing to the owner and a response watchdog.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [ADDR_W-1:0]  ifu_addr,
  output logic               ifu_resp_valid,
  output logic [DATA_W-1:0]  ifu_rdata,
  output logic               ifu_err,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [ADDR_W-1:0]  lsu_addr,
  input  logic               lsu_wen,
  input  logic [DATA_W-1:0]  lsu_wdata,
  input  logic [WMASK_W-1:0] lsu_wmask,
  output logic               lsu_resp_valid,
  output logic [DATA_W-1:0]  lsu_rdata,
  output logic               lsu_err,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_wen,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  input  logic               mem_resp_valid,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e         state_q, state_d;
  arb_owner_e         owner_q, owner_d;
  arb_owner_e         last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [WMASK_W-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]         grant;
  logic               resp_valid;
  logic               resp_err;
  logic [DATA_W-1:0]  resp_data;
  logic               timeout_hit;

  arb_rr2 u_arb_rr2 (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= ARB_IFU;
      last_grant_q <= ARB_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    cnt_d         = cnt_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    resp_err      = 1'b0;
    resp_data     = '0;

    case (state_q)
      ARB_IDLE: begin
        ifu_req_ready = grant[0];
        lsu_req_ready = grant[1];
        if (|grant) begin
          owner_d      = owner_from_grant(grant);
          last_grant_d = owner_from_grant(grant);
          state_d      = ARB_REQ;
          if (grant[1]) begin
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ARB_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = ARB_WAIT;
          cnt_d   = '0;
        end
      end
      ARB_WAIT: begin
        // A real response always beats the watchdog on the same cycle.
        if (mem_resp_valid || timeout_hit) begin
          resp_valid = 1'b1;
          resp_err   = !mem_resp_valid;
          resp_data  = mem_resp_valid ? mem_rdata : '0;
          state_d    = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_comb begin
    ifu_resp_valid = resp_valid && (owner_q == ARB_IFU);
    ifu_err        = resp_err && (owner_q == ARB_IFU);
    ifu_rdata      = (owner_q == ARB_IFU) ? resp_data : '0;
    lsu_resp_valid = resp_valid && (owner_q == ARB_LSU);
    lsu_err        = resp_err && (owner_q == ARB_LSU);
    lsu_rdata      = (owner_q == ARB_LSU) ? resp_data : '0;
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin alternation, store hold,
// watchdog timing and mid-transaction reset, with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_err;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int vecs = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .ifu_err        (ifu_err),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .lsu_err        (lsu_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    ifu_req_valid  = 1'b0;
    ifu_addr       = '0;
    lsu_req_valid  = 1'b0;
    lsu_addr       = '0;
    lsu_wen        = 1'b0;
    lsu_wdata      = '0;
    lsu_wmask      = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;

    // Reset state
    @(negedge clk);
    tick();
    #1;
    chk("rst_ifu_ready", ifu_req_ready, 0);
    chk("rst_lsu_ready", lsu_req_ready, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ifu_resp", ifu_resp_valid, 0);
    chk("rst_lsu_resp", lsu_resp_valid, 0);
    rst_n = 1'b1;
    tick();

    // Lone IFU fetch, accepted at T
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h8000_0000;
    #1;
    chk("ifu_ready_T", ifu_req_ready, 1);
    chk("lsu_ready_T", lsu_req_ready, 0);
    chk("mem_valid_T", mem_req_valid, 0);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    chk("mem_valid_T1", mem_req_valid, 1);
    chk("mem_addr_T1", mem_addr, 64'h8000_0000);
    chk("mem_wen_T1", mem_wen, 0);
    chk("mem_wmask_T1", mem_wmask, 0);
    chk("ifu_ready_T1", ifu_req_ready, 0);
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("ifu_resp_T2", ifu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h0010_0093;
    #1;
    chk("ifu_resp_T3", ifu_resp_valid, 1);
    chk("ifu_rdata_T3", ifu_rdata, 64'h0010_0093);
    chk("ifu_err_T3", ifu_err, 0);
    chk("lsu_resp_T3", lsu_resp_valid, 0);
    chk("lsu_rdata_T3", lsu_rdata, 0);
    $display("xact ifu fetch addr=%h rdata=%h", 64'h8000_0000, ifu_rdata);
    tick();

    // Back-to-back: response at N, grant at N+1, mem request at N+2
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 64'h8000_0004;
    #1;
    chk("b2b_ready_N1", ifu_req_ready, 1);
    tick();
    ifu_req_valid = 1'b0;
    #1;
    chk("b2b_mem_valid_N2", mem_req_valid, 1);
    chk("b2b_mem_addr_N2", mem_addr, 64'h8000_0004);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h0000_0013;
    #1;
    chk("b2b_resp", ifu_resp_valid, 1);
    $display("xact ifu fetch addr=%h rdata=%h", 64'h8000_0004, ifu_rdata);
    tick();
    mem_resp_valid = 1'b0;

    // Contention straight out of reset: IFU first, then strict alternation
    rst_n = 1'b0;
    tick();
    rst_n         = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr      = 64'h100;
    lsu_addr      = 64'h200;
    lsu_wen       = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic exp_lsu;
      exp_lsu = (i % 2) == 1;
      #1;
      chk("rr_ifu_ready", ifu_req_ready, !exp_lsu);
      chk("rr_lsu_ready", lsu_req_ready, exp_lsu);
      tick();
      #1;
      chk("rr_mem_addr", mem_addr, exp_lsu ? 64'h200 : 64'h100);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 64'(i + 1);
      #1;
      chk("rr_ifu_resp", ifu_resp_valid, !exp_lsu);
      chk("rr_lsu_resp", lsu_resp_valid, exp_lsu);
      chk("rr_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 64'(i + 1));
      $display("xact rr %0d owner=%s addr=%h", i, exp_lsu ? "lsu" : "ifu", mem_addr);
      tick();
      mem_resp_valid = 1'b0;
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;

    // LSU store held through three cycles of backpressure
    lsu_req_valid = 1'b1;
    lsu_addr      = 64'h8000_1000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 64'hdead_beef;
    lsu_wmask     = 8'hff;
    #1;
    chk("st_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid = 1'b0;
    lsu_wen       = 1'b0;
    lsu_wdata     = '0;
    lsu_wmask     = '0;
    lsu_addr      = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_mem_valid", mem_req_valid, 1);
      chk("st_mem_addr", mem_addr, 64'h8000_1000);
      chk("st_mem_wen", mem_wen, 1);
      chk("st_mem_wdata", mem_wdata, 64'hdead_beef);
      chk("st_mem_wmask", mem_wmask, 8'hff);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #1;
    chk("st_no_resp_yet", lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h0;
    #1;
    chk("st_ack", lsu_resp_valid, 1);
    chk("st_err", lsu_err, 0);
    chk("st_ifu_quiet", ifu_resp_valid, 0);
    $display("xact lsu store addr=%h wdata=%h", 64'h8000_1000, 64'hdead_beef);
    tick();
    mem_resp_valid = 1'b0;

    // Watchdog: error exactly 4 cycles after the memory handshake
    lsu_req_valid = 1'b1;
    lsu_addr      = 64'h8000_2000;
    #1;
    chk("to_ready", lsu_req_ready, 1);
    tick();
    lsu_req_valid  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'hbad;
    #1;
    chk("to_req_resp_ignored", lsu_resp_valid, 0);
    tick();
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("to_quiet", lsu_resp_valid, 0);
      tick();
    end
    #1;
    chk("to_resp", lsu_resp_valid, 1);
    chk("to_err", lsu_err, 1);
    chk("to_rdata", lsu_rdata, 0);
    chk("to_ifu_quiet", ifu_resp_valid, 0);
    $display("xact lsu load addr=%h timeout", 64'h8000_2000);
    tick();
    lsu_req_valid = 1'b1;
    #1;
    chk("to_idle_after", lsu_req_ready, 1);
    tick();

    // Response on the timeout cycle wins over the error
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h1234;
    #1;
    chk("late_resp", lsu_resp_valid, 1);
    chk("late_err", lsu_err, 0);
    chk("late_rdata", lsu_rdata, 64'h1234);
    $display("xact lsu load addr=%h rdata=%h", 64'h8000_2000, lsu_rdata);
    tick();
    mem_resp_valid = 1'b0;

    // Reset while in WAIT abandons the transaction
    ifu_req_valid = 1'b1;
    ifu_addr      = 64'h300;
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 64'h55;
    #1;
    chk("rw_ifu_resp", ifu_resp_valid, 0);
    chk("rw_ifu_rdata", ifu_rdata, 0);
    chk("rw_ifu_err", ifu_err, 0);
    chk("rw_lsu_resp", lsu_resp_valid, 0);
    chk("rw_mem_valid", mem_req_valid, 0);
    chk("rw_mem_addr", mem_addr, 0);
    tick();
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b1;
    #1;
    chk("rw_idle_grant", ifu_req_ready, 1);
    $display("xact ifu fetch addr=%h abandoned by reset", 64'h300);
    tick();
    ifu_req_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
